ks_sub12_pipe: RTL and testbench

- Pipelined Kogge-Stone subtractor. Computes D = A - B on WIDTH-bit unsigned operands and produces a borrow-out.
- It is the inverse-direction companion to the team's 12-bit Kogge-Stone adder. The same Entry, Propagate, Generate and Sum cell structure is used, with B inverted and carry-in tied to 1.
- Unlike the adder, every tree level is registered and wrapped in a valid/ready handshake. This lets it sit in streaming datapaths with downstream backpressure.

---
 rtl/ks_sub12_pipe_if.sv | 45 ++++
 rtl/ks_sub12_pipe.sv | 91 +++++++++
 tb/tb_ks_sub12_pipe.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ks_sub12_pipe_if.sv
// Operand/result handshake bundle for ks_sub12_pipe.
// Ov exists only when KS_SUB_OVF_FLAG_EN is defined.
interface ks_sub12_pipe_if #(
    parameter int WIDTH = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bo;
`ifdef KS_SUB_OVF_FLAG_EN
    logic             Ov;
`endif

    modport master (
        output in_valid,
        output A,
        output B,
        output out_ready,
`ifdef KS_SUB_OVF_FLAG_EN
        input  Ov,
`endif
        input  in_ready,
        input  out_valid,
        input  D,
        input  Bo
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  out_ready,
`ifdef KS_SUB_OVF_FLAG_EN
        output Ov,
`endif
        output in_ready,
        output out_valid,
        output D,
        output Bo
    );
endinterface

// File: rtl/ks_sub12_pipe.sv
// Pipelined Kogge-Stone subtractor D = A - B with borrow-out, one prefix level per stage.
// Optional signed overflow output Ov when KS_SUB_OVF_FLAG_EN is defined.
module ks_sub12_pipe #(
    parameter int  WIDTH  = 12,
    localparam int LEVELS = $clog2(WIDTH)
) (
    input logic            clk,
    input logic            rst,
    ks_sub12_pipe_if.slave bus
);
    logic             advance_s;
    logic [WIDTH-1:0] p_ent_s;
    logic [WIDTH-1:0] g_ent_s;
    logic [WIDTH-1:0] c_s;
    logic [WIDTH-1:0] d_nxt_s;
    logic             cout_s;

    // Prefix vectors are shifted up one bit so bit 0 carries the folded carry-in (G=1, P=0).
    logic [LEVELS:0]  v_r;
    logic [WIDTH-1:0] g_r  [0:LEVELS];
    logic [WIDTH-1:0] p_r  [0:LEVELS-1];
    logic [WIDTH-1:0] po_r [0:LEVELS];
    logic [LEVELS:0]  gmsb_r;

    logic             out_valid_r;
    logic [WIDTH-1:0] d_r;
    logic             bo_r;
`ifdef KS_SUB_OVF_FLAG_EN
    logic             ov_r;
`endif

    assign advance_s    = ~out_valid_r | bus.out_ready;
    assign bus.in_ready = advance_s;

    assign p_ent_s = bus.A ^ ~bus.B;
    assign g_ent_s = bus.A & ~bus.B;

    // After the last level, group generate at bit i is the carry into original bit i.
    assign c_s     = g_r[LEVELS];
    assign d_nxt_s = po_r[LEVELS] ^ c_s;
    assign cout_s  = gmsb_r[LEVELS] | (po_r[LEVELS][WIDTH-1] & c_s[WIDTH-1]);

    assign bus.out_valid = out_valid_r;
    assign bus.D         = d_r;
    assign bus.Bo        = bo_r;
`ifdef KS_SUB_OVF_FLAG_EN
    assign bus.Ov        = ov_r;
`endif

    // Pipeline registers: every stage shifts together on advance, otherwise all hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_r         <= {(LEVELS+1){1'b0}};
            gmsb_r      <= {(LEVELS+1){1'b0}};
            for (int l = 0; l <= LEVELS; l++) begin
                g_r[l]  <= {WIDTH{1'b0}};
                po_r[l] <= {WIDTH{1'b0}};
            end
            for (int l = 0; l < LEVELS; l++) begin
                p_r[l]  <= {WIDTH{1'b0}};
            end
            out_valid_r <= 1'b0;
            d_r         <= {WIDTH{1'b0}};
            bo_r        <= 1'b0;
`ifdef KS_SUB_OVF_FLAG_EN
            ov_r        <= 1'b0;
`endif
        end else if (advance_s) begin
            v_r[0]    <= bus.in_valid;
            g_r[0]    <= {g_ent_s[WIDTH-2:0], 1'b1};
            p_r[0]    <= {p_ent_s[WIDTH-2:0], 1'b0};
            po_r[0]   <= p_ent_s;
            gmsb_r[0] <= g_ent_s[WIDTH-1];
            for (int l = 1; l <= LEVELS; l++) begin
                v_r[l]    <= v_r[l-1];
                g_r[l]    <= g_r[l-1] | (p_r[l-1] & (g_r[l-1] << (32'd1 << (l - 1))));
                po_r[l]   <= po_r[l-1];
                gmsb_r[l] <= gmsb_r[l-1];
            end
            for (int l = 1; l < LEVELS; l++) begin
                p_r[l]    <= p_r[l-1] & (p_r[l-1] << (32'd1 << (l - 1)));
            end
            out_valid_r <= v_r[LEVELS];
            d_r         <= d_nxt_s;
            bo_r        <= ~cout_s;
`ifdef KS_SUB_OVF_FLAG_EN
            ov_r        <= c_s[WIDTH-1] ^ cout_s;
`endif
        end
    end
endmodule

// File: tb/tb_ks_sub12_pipe.sv
// Self-checking bench for ks_sub12_pipe: directed boundaries plus random streams
// checked against an arithmetic reference model.
module tb_ks_sub12_pipe;
    localparam int WIDTH = 12;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bo;
        logic             ov;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    ks_sub12_pipe_if #(.WIDTH(WIDTH)) bus ();
    ks_sub12_pipe #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        int   ua, ub, sa, sb, diff;
        ua = int'(a);
        ub = int'(b);
        sa = a[WIDTH-1] ? ua - 4096 : ua;
        sb = b[WIDTH-1] ? ub - 4096 : ub;
        diff = ua - ub;
        e.d  = diff[WIDTH-1:0];
        e.bo = (ua < ub);
        e.ov = ((sa - sb) > 2047) || ((sa - sb) < -2048);
        return e;
    endfunction

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.D !== 12'h000) $display("FAIL reset_D got=%h want=000", bus.D); else n_pass++;
        n_checks++; if (bus.Bo !== 1'b0) $display("FAIL reset_Bo got=%b want=0", bus.Bo); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); else n_pass++;
        rst = 1'b1;
    endtask

    // Single pairs with fixed expectations; result must appear on exactly the 6th edge.
    task automatic test_basic;
        logic [WIDTH-1:0] ta [3] = '{12'h005, 12'h000, 12'hABC};
        logic [WIDTH-1:0] tb [3] = '{12'h003, 12'h001, 12'hABC};
        logic [WIDTH-1:0] td [3] = '{12'h002, 12'hFFF, 12'h000};
        logic             tbo[3] = '{1'b0, 1'b1, 1'b0};
        bus.out_ready = 1'b1;
        for (int t = 0; t < 3; t++) begin
            bus.A = ta[t];
            bus.B = tb[t];
            bus.in_valid = 1'b1;
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk);
                #1;
                if (k == 1) bus.in_valid = 1'b0;
                n_checks++;
                if (bus.out_valid !== (k == 6))
                    $display("FAIL basic%0d_valid_edge%0d got=%b want=%b", t, k, bus.out_valid, (k == 6));
                else n_pass++;
                if (k == 6) begin
                    n_checks++; if (bus.D !== td[t]) $display("FAIL basic%0d_D got=%h want=%h", t, bus.D, td[t]); else n_pass++;
                    n_checks++; if (bus.Bo !== tbo[t]) $display("FAIL basic%0d_Bo got=%b want=%b", t, bus.Bo, tbo[t]); else n_pass++;
                end
            end
        end
    endtask

    task automatic test_stream;
        exp_t             e;
        int               sent = 0, got = 0;
        logic             acc, dlv, obo, oov;
        logic [WIDTH-1:0] od;
        q.delete();
        bus.out_ready = 1'b1;
        bus.A = WIDTH'($urandom);
        bus.B = WIDTH'($urandom);
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
            #1;
            acc = bus.in_valid & bus.in_ready;
            dlv = bus.out_valid & bus.out_ready;
            od  = bus.D;
            obo = bus.Bo;
`ifdef KS_SUB_OVF_FLAG_EN
            oov = bus.Ov;
`else
            oov = 1'b0;
`endif
            if (got > 0) begin
                n_checks++;
                if (bus.out_valid !== 1'b1) $display("FAIL stream_gap after %0d results got=%b want=1", got, bus.out_valid);
                else n_pass++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                q.push_back(model(bus.A, bus.B));
                sent++;
                if (sent < 20) begin
                    bus.A = WIDTH'($urandom);
                    bus.B = WIDTH'($urandom);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (dlv) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL stream_unexpected result D=%h want none", od);
                end else begin
                    e = q.pop_front();
                    if (od !== e.d || obo !== e.bo || (oov !== e.ov && 1'b0 !== oov))
                        $display("FAIL stream_result%0d got=%h/%b/%b want=%h/%b/%b", got, od, obo, oov, e.d, e.bo, e.ov);
                    else n_pass++;
                end
                got++;
            end
        end
        n_checks++; if (got != 20) $display("FAIL stream_count got=%0d want=20", got); else n_pass++;
    endtask

    task automatic test_back_to_back_stall;
        exp_t             e;
        int               sent = 0, got = 0;
        logic             acc, dlv, have_held = 1'b0;
        logic [WIDTH-1:0] od, held_d;
        q.delete();
        bus.out_ready = 1'b0;
        bus.A = WIDTH'($urandom);
        bus.B = WIDTH'($urandom);
        bus.in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            if (cyc == 10) begin
                n_checks++; if (sent != 6) $display("FAIL stall_accepted got=%0d want=6", sent); else n_pass++;
                n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_in_ready got=%b want=0", bus.in_ready); else n_pass++;
                bus.out_ready = 1'b1;
            end
            #1;
            acc = bus.in_valid & bus.in_ready;
            dlv = bus.out_valid & bus.out_ready;
            od  = bus.D;
            if (bus.out_valid && !bus.out_ready) begin
                if (have_held) begin
                    n_checks++;
                    if (od !== held_d) $display("FAIL stall_D_stable got=%h want=%h", od, held_d); else n_pass++;
                end
                held_d = od;
                have_held = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                q.push_back(model(bus.A, bus.B));
                sent++;
                if (sent < 8) begin
                    bus.A = WIDTH'($urandom);
                    bus.B = WIDTH'($urandom);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            if (dlv) begin
                n_checks++;
                if (q.size() == 0) begin
                    $display("FAIL stall_unexpected result D=%h want none", od);
                end else begin
                    e = q.pop_front();
                    if (od !== e.d) $display("FAIL stall_result%0d got=%h want=%h", got, od, e.d); else n_pass++;
                end
                got++;
            end
        end
        n_checks++; if (got != 8) $display("FAIL stall_count got=%0d want=8", got); else n_pass++;
    endtask

    task automatic test_reset_midflight;
        int seen = 0;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.A = WIDTH'($urandom);
            bus.B = WIDTH'($urandom);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        for (int k = 0; k < 20 && !bus.out_valid; k++) begin
            @(posedge clk);
            #1;
            seen++;
        end
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL midrst_fill got=%b want=1", bus.out_valid); else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%b want=0", bus.out_valid); else n_pass++;
        n_checks++; if (bus.D !== 12'h000) $display("FAIL midrst_D got=%h want=000", bus.D); else n_pass++;
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        bus.A = 12'h010;
        bus.B = 12'h001;
        bus.in_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) bus.in_valid = 1'b0;
            n_checks++;
            if (bus.out_valid !== (k == 6)) $display("FAIL midrst_valid_edge%0d got=%b want=%b", k, bus.out_valid, (k == 6));
            else n_pass++;
            if (k == 6) begin
                n_checks++; if (bus.D !== 12'h00F) $display("FAIL midrst_D_after got=%h want=00F", bus.D); else n_pass++;
            end
        end
    endtask

`ifdef KS_SUB_OVF_FLAG_EN
    task automatic test_overflow;
        logic [WIDTH-1:0] ta [2] = '{12'h800, 12'h7FF};
        logic [WIDTH-1:0] tb [2] = '{12'h001, 12'hFFF};
        logic [WIDTH-1:0] td [2] = '{12'h7FF, 12'h800};
        logic             tbo[2] = '{1'b0, 1'b1};
        bus.out_ready = 1'b1;
        for (int t = 0; t < 2; t++) begin
            bus.A = ta[t];
            bus.B = tb[t];
            bus.in_valid = 1'b1;
            for (int k = 1; k <= 7; k++) begin
                @(posedge clk);
                #1;
                if (k == 1) bus.in_valid = 1'b0;
                if (k == 6) begin
                    n_checks++;
                    if (bus.out_valid !== 1'b1 || bus.D !== td[t] || bus.Bo !== tbo[t] || bus.Ov !== 1'b1)
                        $display("FAIL ovf%0d got=%b/%h/%b/%b want=1/%h/%b/1", t, bus.out_valid, bus.D, bus.Bo, bus.Ov, td[t], tbo[t]);
                    else n_pass++;
                end
            end
        end
    endtask
`endif

    initial begin
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = 12'h000;
        bus.B         = 12'h000;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_stream();
        test_back_to_back_stall();
        test_reset_midflight();
`ifdef KS_SUB_OVF_FLAG_EN
        test_overflow();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
